// File: rtl/mips_muldiv_alu.sv
// Sequenced MIPS ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide into HI/LO, with a start/busy/done handshake.
module mips_muldiv_alu #(
    parameter int WORD_SIZE = 32,
    parameter int OP_SIZE   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OP_SIZE-1:0]   sel,
    input  logic [WORD_SIZE-1:0] data_1,
    input  logic [WORD_SIZE-1:0] data_2,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] alu_out,
    output logic                 alu_zero_flag,
    output logic                 overflow,
    output logic                 div_by_zero,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int SHW = $clog2(WORD_SIZE);
    localparam logic [WORD_SIZE-1:0] ZERO_W = {WORD_SIZE{1'b0}};
    localparam logic [WORD_SIZE-1:0] ONES_W = {WORD_SIZE{1'b1}};
    localparam logic [WORD_SIZE-1:0] ONE_W  = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]       CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]       CNT_LAST = SHW'(WORD_SIZE-1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [WORD_SIZE-1:0]    alu_out_q, alu_out_d, hi_q, hi_d, lo_q, lo_d;
    logic                    zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
    logic [2*WORD_SIZE-1:0]  acc_q, acc_d;
    logic [WORD_SIZE-1:0]    opnd_q, opnd_d;
    logic [SHW-1:0]          cnt_q, cnt_d;
    logic                    is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

    logic [3:0]              op_s;
    logic [SHW-1:0]          shamt_s;
    logic                    is_signed_s, sign_a_s, sign_b_s;
    logic [WORD_SIZE-1:0]    opa_s, opb_s, sum_s, diff_s;
    logic [WORD_SIZE:0]      mul_sum_s, div_trial_s, div_diff_s;
    logic [2*WORD_SIZE-1:0]  prod_fix_s;

    // Out-of-range opcodes fall back to ADD.
    assign op_s        = ((sel >> 3'd4) != {OP_SIZE{1'b0}}) ? 4'h0 : sel[3:0];
    assign shamt_s     = data_2[SHW-1:0];
    assign sign_a_s    = data_1[WORD_SIZE-1];
    assign sign_b_s    = data_2[WORD_SIZE-1];
    assign is_signed_s = (op_s == 4'hB) || (op_s == 4'hD);
    assign opa_s       = (is_signed_s && sign_a_s) ? -data_1 : data_1;
    assign opb_s       = (is_signed_s && sign_b_s) ? -data_2 : data_2;
    assign sum_s       = data_1 + data_2;
    assign diff_s      = data_1 - data_2;
    assign mul_sum_s   = {1'b0, acc_q[2*WORD_SIZE-1:WORD_SIZE]}
                       + (acc_q[0] ? {1'b0, opnd_q} : {(WORD_SIZE+1){1'b0}});
    assign div_trial_s = {acc_q[2*WORD_SIZE-1:WORD_SIZE], acc_q[WORD_SIZE-1]};
    assign div_diff_s  = div_trial_s - {1'b0, opnd_q};
    assign prod_fix_s  = neg_lo_q ? -acc_q : acc_q;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b0;
                    case (op_s)
                        4'h0: begin
                            alu_out_d = sum_s;
                            ovf_d = (sign_a_s == sign_b_s) && (sum_s[WORD_SIZE-1] != sign_a_s);
                        end
                        4'h1: begin
                            alu_out_d = diff_s;
                            ovf_d = (sign_a_s != sign_b_s) && (diff_s[WORD_SIZE-1] != sign_a_s);
                        end
                        4'h2: alu_out_d = data_1 & data_2;
                        4'h3: alu_out_d = data_1 | data_2;
                        4'h4: alu_out_d = data_1 ^ data_2;
                        4'h5: alu_out_d = ~(data_1 | data_2);
                        4'h6: alu_out_d = ($signed(data_1) < $signed(data_2)) ? ONE_W : ZERO_W;
                        4'h7: alu_out_d = (data_1 < data_2) ? ONE_W : ZERO_W;
                        4'h8: alu_out_d = data_1 << shamt_s;
                        4'h9: alu_out_d = data_1 >> shamt_s;
                        4'hA: alu_out_d = $signed(data_1) >>> shamt_s;
                        4'hB, 4'hC: begin
                            done_d   = 1'b0;
                            busy_d   = 1'b1;
                            state_d  = MUL;
                            acc_d    = {ZERO_W, opb_s};
                            opnd_d   = opa_s;
                            cnt_d    = {SHW{1'b0}};
                            is_div_d = 1'b0;
                            neg_lo_d = is_signed_s && (sign_a_s ^ sign_b_s);
                            neg_hi_d = 1'b0;
                        end
                        4'hD, 4'hE: begin
                            if (data_2 == ZERO_W) begin
                                dbz_d     = 1'b1;
                                alu_out_d = ONES_W;
                            end else begin
                                done_d   = 1'b0;
                                busy_d   = 1'b1;
                                state_d  = DIV;
                                acc_d    = {ZERO_W, opa_s};
                                opnd_d   = opb_s;
                                cnt_d    = {SHW{1'b0}};
                                is_div_d = 1'b1;
                                neg_lo_d = is_signed_s && (sign_a_s ^ sign_b_s);
                                neg_hi_d = is_signed_s && sign_a_s;
                            end
                        end
                        4'hF: alu_out_d = data_2 << (WORD_SIZE / 2);
                        default: alu_out_d = sum_s;
                    endcase
                    zero_d = (alu_out_d == ZERO_W);
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d = {mul_sum_s, acc_q[WORD_SIZE-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    state_d = MUL;
                end
            end
            DIV: begin
                // Restoring step: subtract only when the trial remainder covers the divisor.
                if (!div_diff_s[WORD_SIZE]) begin
                    acc_d = {div_diff_s[WORD_SIZE-1:0], acc_q[WORD_SIZE-2:0], 1'b1};
                end else begin
                    acc_d = {div_trial_s[WORD_SIZE-1:0], acc_q[WORD_SIZE-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    state_d = DIV;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WORD_SIZE-1:0] : acc_q[WORD_SIZE-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WORD_SIZE-1:WORD_SIZE] : acc_q[2*WORD_SIZE-1:WORD_SIZE];
                end else begin
                    lo_d = prod_fix_s[WORD_SIZE-1:0];
                    hi_d = prod_fix_s[2*WORD_SIZE-1:WORD_SIZE];
                end
                alu_out_d = lo_d;
                zero_d    = (lo_d == ZERO_W);
                ovf_d     = 1'b0;
                dbz_d     = 1'b0;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_out_q <= ZERO_W;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            acc_q     <= {2*WORD_SIZE{1'b0}};
            opnd_q    <= ZERO_W;
            cnt_q     <= {SHW{1'b0}};
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign alu_out       = alu_out_q;
    assign alu_zero_flag = zero_q;
    assign overflow      = ovf_q;
    assign div_by_zero   = dbz_q;
    assign hi            = hi_q;
    assign lo            = lo_q;

endmodule

// File: tb/tb_mips_muldiv_alu.sv
// Bench for mips_muldiv_alu (WORD_SIZE=32): directed scenarios plus random ops
// compared against a plain-arithmetic reference model of the opcode set.
module tb_mips_muldiv_alu;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  sel;
    logic [31:0] data_1, data_2;
    logic        busy, done, alu_zero_flag, overflow, div_by_zero;
    logic [31:0] alu_out, hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    mips_muldiv_alu #(.WORD_SIZE(32), .OP_SIZE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .data_1(data_1), .data_2(data_2),
        .busy(busy), .done(done), .alu_out(alu_out),
        .alu_zero_flag(alu_zero_flag), .overflow(overflow),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    // Reference model: results from integer arithmetic on the operands' numeric values.
    task automatic model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eo, output logic [31:0] ehi, output logic [31:0] elo,
                         output logic eovf, output logic edbz, output int elat);
        longint sa, sb, r;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ehi = m_hi; elo = m_lo; eovf = 1'b0; edbz = 1'b0; elat = 1; eo = 32'h0;
        case (s)
            4'h0: begin r = sa + sb; eo = a + b; eovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h1: begin r = sa - sb; eo = a - b; eovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h2: eo = a & b;
            4'h3: eo = a | b;
            4'h4: eo = a ^ b;
            4'h5: eo = ~(a | b);
            4'h6: eo = (sa < sb) ? 32'd1 : 32'd0;
            4'h7: eo = (ua < ub) ? 32'd1 : 32'd0;
            4'h8: eo = a << b[4:0];
            4'h9: eo = a >> b[4:0];
            4'hA: eo = $unsigned($signed(a) >>> b[4:0]);
            4'hB: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; eo = elo; elat = 34; end
            4'hC: begin p = ua * ub; ehi = p[63:32]; elo = p[31:0]; eo = elo; elat = 34; end
            4'hD, 4'hE: begin
                if (b == 32'h0) begin
                    edbz = 1'b1; eo = 32'hFFFFFFFF;
                end else begin
                    if (s == 4'hD) begin
                        p = sa / sb; elo = p[31:0];
                        p = sa % sb; ehi = p[31:0];
                    end else begin
                        p = ua / ub; elo = p[31:0];
                        p = ua % ub; ehi = p[31:0];
                    end
                    eo = elo; elat = 34;
                end
            end
            default: eo = b << 16;
        endcase
    endtask

    task automatic do_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output int bcnt, output logic got);
        @(posedge clk); #1;
        start = 1'b1; sel = s; data_1 = a; data_2 = b;
        @(posedge clk); #1;
        start = 1'b0; sel = 4'($urandom); data_1 = $urandom; data_2 = $urandom;
        cyc = 1; bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        got = done;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sel = 4'h0; data_1 = 32'h0; data_2 = 32'h0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        checks++;
        if ({busy, done, alu_out, alu_zero_flag, overflow, div_by_zero, hi, lo} !== 101'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b out=%h z=%b ovf=%b dbz=%b hi=%h lo=%h (all must be 0)",
                     busy, done, alu_out, alu_zero_flag, overflow, div_by_zero, hi, lo);
        end
    endtask

    task automatic test_add_sub();
        int cyc, bcnt; logic got;
        do_op(4'h0, 32'h7FFFFFFF, 32'h00000001, cyc, bcnt, got);
        checks++;
        if ({got, alu_out, overflow, alu_zero_flag} !== {1'b1, 32'h80000000, 1'b1, 1'b0} || cyc != 1) begin
            failures++;
            $display("FAIL add_ovf done=%b cyc=%0d out=%h ovf=%b z=%b exp done=1 cyc=1 out=80000000 ovf=1 z=0",
                     got, cyc, alu_out, overflow, alu_zero_flag);
        end
        do_op(4'h1, 32'd5, 32'd5, cyc, bcnt, got);
        checks++;
        if ({got, alu_out, overflow, alu_zero_flag} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_zero done=%b out=%h ovf=%b z=%b exp done=1 out=0 ovf=0 z=1",
                     got, alu_out, overflow, alu_zero_flag);
        end
    endtask

    task automatic test_mul();
        int cyc, bcnt; logic got;
        do_op(4'hB, 32'hFFFFFFFD, 32'h00000007, cyc, bcnt, got);
        checks++;
        if (!got || cyc != 34 || bcnt != 33 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mult_timing done=%b cyc=%0d busy_cycles=%0d busy_at_done=%b exp 1/34/33/0",
                     got, cyc, bcnt, busy);
        end
        checks++;
        if ({hi, lo, alu_out} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFEB}) begin
            failures++;
            $display("FAIL mult_result hi=%h lo=%h out=%h exp ffffffff ffffffeb ffffffeb", hi, lo, alu_out);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse done=%b exp 0 one cycle after done", done);
        end
        do_op(4'hC, 32'hFFFFFFFD, 32'h00000007, cyc, bcnt, got);
        checks++;
        if (!got || cyc != 34 || {hi, lo} !== {32'h00000006, 32'hFFFFFFEB}) begin
            failures++;
            $display("FAIL multu_result done=%b cyc=%0d hi=%h lo=%h exp 1/34 00000006 ffffffeb", got, cyc, hi, lo);
        end
        m_hi = 32'h00000006; m_lo = 32'hFFFFFFEB;
    endtask

    task automatic test_div();
        int cyc, bcnt; logic got;
        do_op(4'hD, 32'hFFFFFFF9, 32'h00000002, cyc, bcnt, got);
        checks++;
        if (!got || cyc != 34 || {hi, lo, alu_out} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD}) begin
            failures++;
            $display("FAIL div_signed done=%b cyc=%0d hi=%h lo=%h out=%h exp 1/34 ffffffff fffffffd fffffffd",
                     got, cyc, hi, lo, alu_out);
        end
        do_op(4'hE, 32'd7, 32'd0, cyc, bcnt, got);
        checks++;
        if (!got || cyc != 1 || bcnt != 0 || div_by_zero !== 1'b1 || alu_out !== 32'hFFFFFFFF
            || {hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            failures++;
            $display("FAIL divu_zero done=%b cyc=%0d busy_cycles=%0d dbz=%b out=%h hi=%h lo=%h exp 1/1/0/1 ffffffff ffffffff fffffffd",
                     got, cyc, bcnt, div_by_zero, alu_out, hi, lo);
        end
        do_op(4'hD, 32'h80000000, 32'hFFFFFFFF, cyc, bcnt, got);
        checks++;
        if (!got || {hi, lo, overflow, div_by_zero} !== {32'h0, 32'h80000000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL div_most_neg done=%b hi=%h lo=%h ovf=%b dbz=%b exp 1 00000000 80000000 0 0",
                     got, hi, lo, overflow, div_by_zero);
        end
        m_hi = 32'h0; m_lo = 32'h80000000;
    endtask

    task automatic test_handshake();
        int cyc, extra;
        @(posedge clk); #1;
        start = 1'b1; sel = 4'hE; data_1 = 32'd100; data_2 = 32'd7;
        @(posedge clk); #1;
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 5) begin
                start = 1'b1; sel = 4'h0; data_1 = 32'd1; data_2 = 32'd1;
            end else begin
                start = 1'b0; data_1 = $urandom; data_2 = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!done || cyc != 34 || {hi, lo, alu_out} !== {32'd2, 32'd14, 32'd14}) begin
            failures++;
            $display("FAIL busy_ignore done=%b cyc=%0d hi=%h lo=%h out=%h exp 1/34 2 e e", done, cyc, hi, lo, alu_out);
        end
        start = 1'b1; sel = 4'h8; data_1 = 32'd1; data_2 = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || alu_out !== 32'h10 || {hi, lo} !== {32'd2, 32'd14}) begin
            failures++;
            $display("FAIL back_to_back done=%b out=%h hi=%h lo=%h exp 1 10 2 e", done, alu_out, hi, lo);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL single_done extra_done=%0d exp 0", extra);
        end
        m_hi = 32'd2; m_lo = 32'd14;
    endtask

    task automatic test_shift_cmp();
        logic [3:0]  t_sel [5] = '{4'hA, 4'h9, 4'h6, 4'h7, 4'hF};
        logic [31:0] t_a   [5] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [31:0] t_b   [5] = '{32'd31, 32'd31, 32'd1, 32'd1, 32'h1234};
        logic [31:0] t_exp [5] = '{32'hFFFFFFFF, 32'h00000001, 32'd1, 32'd0, 32'h12340000};
        int cyc, bcnt; logic got;
        for (int i = 0; i < 5; i++) begin
            do_op(t_sel[i], t_a[i], t_b[i], cyc, bcnt, got);
            checks++;
            if (!got || cyc != 1 || alu_out !== t_exp[i] || alu_zero_flag !== (t_exp[i] == 32'h0)) begin
                failures++;
                $display("FAIL shift_cmp[%0d] sel=%h done=%b cyc=%0d out=%h z=%b exp out=%h cyc=1",
                         i, t_sel[i], got, cyc, alu_out, alu_zero_flag, t_exp[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int cyc, bcnt, extra; logic got;
        @(posedge clk); #1;
        start = 1'b1; sel = 4'hB; data_1 = 32'h12345; data_2 = 32'h777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        checks++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            failures++;
            $display("FAIL reset_midop busy=%b done=%b hi=%h lo=%h exp all 0", busy, done, hi, lo);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL abort_no_done done_count=%0d exp 0", extra);
        end
        do_op(4'h0, 32'd2, 32'd3, cyc, bcnt, got);
        checks++;
        if (!got || cyc != 1 || alu_out !== 32'd5) begin
            failures++;
            $display("FAIL add_after_reset done=%b cyc=%0d out=%h exp 1/1/5", got, cyc, alu_out);
        end
    endtask

    task automatic test_random();
        logic [3:0] s; logic [31:0] a, b, eo, ehi, elo; logic eovf, edbz;
        int elat, cyc, bcnt; logic got;
        for (int n = 0; n < 60; n++) begin
            s = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            model(s, a, b, eo, ehi, elo, eovf, edbz, elat);
            do_op(s, a, b, cyc, bcnt, got);
            checks++;
            if (!got || cyc != elat || bcnt != elat - 1) begin
                failures++;
                $display("FAIL rnd_timing[%0d] sel=%h done=%b cyc=%0d busy_cycles=%0d exp cyc=%0d busy=%0d",
                         n, s, got, cyc, bcnt, elat, elat - 1);
            end
            checks++;
            if ({alu_out, alu_zero_flag, overflow, div_by_zero} !== {eo, (eo == 32'h0), eovf, edbz}) begin
                failures++;
                $display("FAIL rnd_out[%0d] sel=%h a=%h b=%h out=%h z=%b ovf=%b dbz=%b exp out=%h z=%b ovf=%b dbz=%b",
                         n, s, a, b, alu_out, alu_zero_flag, overflow, div_by_zero, eo, (eo == 32'h0), eovf, edbz);
            end
            checks++;
            if ({hi, lo} !== {ehi, elo}) begin
                failures++;
                $display("FAIL rnd_hilo[%0d] sel=%h a=%h b=%h hi=%h lo=%h exp hi=%h lo=%h",
                         n, s, a, b, hi, lo, ehi, elo);
            end
            m_hi = ehi; m_lo = elo;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_handshake();
        test_shift_cmp();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
